// File: rtl/inv_neg_seq_if.sv
// Operand/result handshake bundle for inv_neg_seq.
// Master drives operands and consumes results; slave is the unit itself.
interface inv_neg_seq_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/inv_neg_seq.sv
// Chunk-serial pass / invert / negate / abs unit, CHUNK bits per RUN cycle.
// Optional macro INV_ABS_EN turns mode 11 into absolute value; otherwise mode 11 is pass.
module inv_neg_seq #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   inv_neg_seq_if.slave  bus,
   output logic          busy
);
   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_nxt;
   logic             accept;
   logic             last;
   logic [KW-1:0]    k_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_nxt;
   logic [WIDTH-1:0] out_data_q;
   logic             inv_q, carry_q, neg_q, msb_q;
   logic             idle_q, out_valid_q, out_ovf_q, busy_q;
   logic             dec_inv, dec_carry;
   logic [CHUNK:0]   sum;

   // Mode decode on the accept edge
   always_comb begin
      dec_inv   = 1'b0;
      dec_carry = 1'b0;
      case (bus.in_mode)
         2'b01: dec_inv = 1'b1;
         2'b10: begin
            dec_inv   = 1'b1;
            dec_carry = 1'b1;
         end
`ifdef INV_ABS_EN
         2'b11: begin
            dec_inv   = bus.in_data[WIDTH-1];
            dec_carry = bus.in_data[WIDTH-1];
         end
`endif
         default: ;
      endcase
   end

   // Low chunk of the shifting operand; results enter at the top of res_q
   always_comb begin
      sum     = {1'b0, data_q[CHUNK-1:0] ^ {CHUNK{inv_q}}} + (CHUNK+1)'(carry_q);
      res_nxt = (res_q >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
      last    = (k_q == KW'(N - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      accept    = 1'b0;
      case (state_q)
         IDLE: if (bus.in_valid) begin
            accept    = 1'b1;
            state_nxt = RUN;
         end
         RUN:  if (last) state_nxt = DONE;
         DONE: if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered status flags track the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_q      <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         idle_q      <= (state_nxt == IDLE);
         out_valid_q <= (state_nxt == DONE);
         busy_q      <= (state_nxt != IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q        <= '0;
         data_q     <= '0;
         res_q      <= '0;
         out_data_q <= '0;
         out_ovf_q  <= 1'b0;
         inv_q      <= 1'b0;
         carry_q    <= 1'b0;
         neg_q      <= 1'b0;
         msb_q      <= 1'b0;
      end else if (accept) begin
         k_q     <= '0;
         data_q  <= bus.in_data;
         res_q   <= '0;
         inv_q   <= dec_inv;
         carry_q <= dec_carry;
         neg_q   <= dec_carry;
         msb_q   <= bus.in_data[WIDTH-1];
      end else if (state_q == RUN) begin
         k_q     <= k_q + KW'(1);
         data_q  <= data_q >> CHUNK;
         res_q   <= res_nxt;
         carry_q <= sum[CHUNK];
         if (last) begin
            out_data_q <= res_nxt;
            out_ovf_q  <= neg_q & msb_q & res_nxt[WIDTH-1];
         end
      end
   end

   assign bus.in_ready  = idle_q & rst_n;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ovf   = out_ovf_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_inv_neg_seq.sv
// Directed scoreboard bench for inv_neg_seq at WIDTH=16, CHUNK=4.
// Build with INV_ABS_EN defined to cover the absolute-value variant.
module tb_inv_neg_seq;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned CHUNK = 4;
   localparam int unsigned N     = WIDTH / CHUNK;

`ifdef INV_ABS_EN
   localparam logic [15:0] ABS_FFFB = 16'h0005;
   localparam logic        ABS_OVF  = 1'b1;
`else
   localparam logic [15:0] ABS_FFFB = 16'hFFFB;
   localparam logic        ABS_OVF  = 1'b0;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic             o;
   } exp_t;

   typedef struct {
      logic [15:0] d;
      logic [1:0]  m;
      logic [15:0] ed;
      logic        eo;
   } op_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic busy;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   inv_neg_seq_if #(.WIDTH(WIDTH)) bus ();

   inv_neg_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one operand, push its expected result, scramble inputs after accept
   task automatic send(input logic [15:0] d, input logic [1:0] m,
                       input logic [15:0] ed, input logic eo);
      int w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_mode  = m;
      sb.push_back('{d: ed, o: eo});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 16'($urandom);
      bus.in_mode  = 2'($urandom);
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("in_ready_in_run", 32'(bus.in_ready), 32'd0);
   endtask

   task automatic collect(input string tag);
      int   cyc = 0;
      exp_t e;
      while (!bus.out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(N));
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_data"}, 32'(bus.out_data), 32'(e.d));
         chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(e.o));
      end
   endtask

   task automatic release_out(input string tag);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
      chk({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      op_t ops[9];
      ops[0] = '{16'h0001, 2'b10, 16'hFFFF, 1'b0};
      ops[1] = '{16'h0000, 2'b10, 16'h0000, 1'b0};
      ops[2] = '{16'h00FF, 2'b01, 16'hFF00, 1'b0};
      ops[3] = '{16'h1234, 2'b00, 16'h1234, 1'b0};
      ops[4] = '{16'h8000, 2'b10, 16'h8000, 1'b1};
      ops[5] = '{16'h7FFF, 2'b10, 16'h8001, 1'b0};
      ops[6] = '{16'hFFFB, 2'b11, ABS_FFFB, 1'b0};
      ops[7] = '{16'h0005, 2'b11, 16'h0005, 1'b0};
      ops[8] = '{16'h8000, 2'b11, 16'h8000, ABS_OVF};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_mode   = '0;
      bus.out_ready = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("release_in_ready", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 9; i++) begin
         send(ops[i].d, ops[i].m, ops[i].ed, ops[i].eo);
         collect($sformatf("op%0d", i));
         release_out($sformatf("op%0d", i));
      end

      // Backpressure: result held, extra operand ignored while in DONE
      send(16'h0F0F, 2'b01, 16'hF0F0, 1'b0);
      collect("bp");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = 16'h1111;
         bus.in_mode  = 2'b10;
         @(posedge clk);
         #1;
         chk("bp_valid_held", 32'(bus.out_valid), 32'd1);
         chk("bp_data_stable", 32'(bus.out_data), 32'hF0F0);
         chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      release_out("bp");
      chk("bp_data_held_idle", 32'(bus.out_data), 32'hF0F0);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("bp_not_queued", 32'(busy), 32'd0);
      end
      send(16'h1111, 2'b10, 16'hEEEF, 1'b0);
      collect("post_bp");
      release_out("post_bp");

      // Reset in the middle of RUN discards the operation
      send(16'h0001, 2'b10, 16'hFFFF, 1'b0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_out_data", 32'(bus.out_data), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_release_in_ready", 32'(bus.in_ready), 32'd1);
      send(16'h0003, 2'b10, 16'hFFFD, 1'b0);
      collect("after_rst");
      release_out("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
